// File: rtl/mul_controller.sv
// Control FSM for the repeated-addition multiplier datapath.
// Optional iteration watchdog and err port are compiled in with MUL_WDOG_EN.
module mul_controller #(
  parameter int unsigned         ITER_W   = 16,
  parameter logic [ITER_W-1:0]   MAX_ITER = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op_valid,
  input  logic done_ack,
  input  logic eqz,
  output logic op_ready,
  output logic op_sel,
  output logic LdA,
  output logic LdB,
  output logic LdP,
  output logic clrP,
  output logic decB,
  output logic busy,
`ifdef MUL_WDOG_EN
  output logic done,
  output logic err
`else
  output logic done
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t nxt;
  logic   abort;

`ifdef MUL_WDOG_EN
  logic [ITER_W-1:0] iter;

  assign abort = (state == ADD) && !eqz && (iter == MAX_ITER);

  // Held at zero outside ADD, so each ADD visit starts counting afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter <= '0;
    end else if (state != ADD) begin
      iter <= '0;
    end else if (!eqz && !abort) begin
      iter <= iter + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (abort) begin
      err <= 1'b1;
    end else if (state == DONE && done_ack) begin
      err <= 1'b0;
    end
  end
`else
  logic [ITER_W-1:0] unused_max_iter;

  assign abort           = 1'b0;
  assign unused_max_iter = MAX_ITER;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start)         nxt = LOADA;
      LOADA:   if (op_valid)      nxt = LOADB;
      LOADB:   if (op_valid)      nxt = ADD;
      ADD:     if (eqz || abort)  nxt = DONE;
      DONE:    if (done_ack)      nxt = IDLE;
      default:                    nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready = 1'b0;
    op_sel   = 1'b0;
    LdA      = 1'b0;
    LdB      = 1'b0;
    LdP      = 1'b0;
    clrP     = 1'b0;
    decB     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      LOADA: begin
        op_ready = 1'b1;
        LdA      = op_valid;
      end
      LOADB: begin
        op_ready = 1'b1;
        op_sel   = 1'b1;
        LdB      = op_valid;
        clrP     = op_valid;
      end
      ADD: begin
        LdP  = !eqz && !abort;
        decB = !eqz && !abort;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_controller.sv
// Self-checking bench for mul_controller with a behavioural datapath
// and an arithmetic reference for product, iteration count and latency.
module tb_mul_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic op_valid = 1'b0;
  logic done_ack = 1'b0;
  logic op_ready, op_sel, LdA, LdB, LdP, clrP, decB, busy, done;

`ifdef MUL_WDOG_EN
  logic err;
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int MAXI = 8;

  logic [15:0] opa = 16'd0;
  logic [15:0] opb = 16'd0;
  logic [15:0] data_in;
  logic [15:0] ra = 16'd0;
  logic [15:0] rb = 16'd0;
  logic [15:0] rp = 16'd0;
  logic        eqz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign data_in = op_sel ? opb : opa;
  assign eqz     = (rb == 16'd0);

  // Datapath the controller drives.
  always @(posedge clk) begin
    if (LdA) ra <= data_in;
    if (LdB) rb <= data_in;
    else if (decB) rb <= rb - 16'd1;
    if (clrP) rp <= 16'd0;
    else if (LdP) rp <= rp + ra;
  end

  mul_controller #(.ITER_W(16), .MAX_ITER(16'(MAXI))) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_valid (op_valid),
    .done_ack (done_ack),
    .eqz      (eqz),
    .op_ready (op_ready),
    .op_sel   (op_sel),
    .LdA      (LdA),
    .LdB      (LdB),
    .LdP      (LdP),
    .clrP     (clrP),
    .decB     (decB),
    .busy     (busy),
`ifdef MUL_WDOG_EN
    .done     (done),
    .err      (err)
`else
    .done     (done)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({op_ready, op_sel, LdA, LdB, LdP, clrP, decB, busy, done});
  endfunction

  // Start a multiply; op_valid stays low for the first `stall` LOADA cycles.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input int stall);
    int  iters;
    int  n_ldp;
    int  i;
    bit  seen;
    bit  ab;
    ab    = WDOG && (int'(b) > MAXI);
    iters = ab ? MAXI : int'(b);
    opa = a;
    opb = b;
    op_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_ldp = 0;
    seen  = 1'b0;
    for (i = 0; i <= stall + iters + 10; i++) begin
      op_valid = (i >= stall);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("busy", 32'(busy), 32'd1);
      if (i < stall) begin
        chk("stall_rdy", 32'({op_ready, op_sel, LdA}), 32'b100);
      end
      if (i == stall) begin
        chk("lda", 32'({op_ready, op_sel, LdA}), 32'b101);
      end
      if (i == stall + 1) begin
        chk("ldb", 32'({op_ready, op_sel, LdB, clrP}), 32'b1111);
      end
      chk("excl", 32'(($countones({LdA, LdB, LdP}) <= 1)
                      && (LdP == decB) && (!clrP || LdB)), 32'd1);
      n_ldp += int'(LdP);
      cyc();
    end
    // IDLE->LOADA->LOADB->ADD, iters accumulate cycles, one exit cycle.
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(i), 32'(stall + 3 + iters));
    chk("ldp_cycles", 32'(n_ldp), 32'(iters));
    chk("product", 32'(rp), 32'(16'(a * 16'(iters))));
    chk("done_outs", outs(), 32'b000000011);
`ifdef MUL_WDOG_EN
    chk("err", 32'(err), 32'(ab));
`endif
    op_valid = 1'b0;
    start = 1'b1;
    cyc();
    chk("done_hold", outs(), 32'b000000011);
    done_ack = 1'b1;
    cyc();
    done_ack = 1'b0;
    start = 1'b0;
    chk("idle_after_ack", outs(), 32'd0);
`ifdef MUL_WDOG_EN
    chk("err_clear", 32'(err), 32'd0);
`endif
    cyc();
    chk("idle_stays", outs(), 32'd0);
  endtask

  initial begin
    #2;
    chk("reset_outs", outs(), 32'd0);
`ifdef MUL_WDOG_EN
    chk("reset_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b1;
    done_ack = 1'b1;
    cyc();
    cyc();
    chk("idle_ignores", outs(), 32'd0);
    op_valid = 1'b0;
    done_ack = 1'b0;

    run_mul(16'd7, 16'd5, 0);
    run_mul(16'd9, 16'd0, 0);
    run_mul(16'd3, 16'd4, 4);
    run_mul(16'd300, 16'd300, 0);
    run_mul(16'd1, 16'd20, 0);
    run_mul(16'd5, 16'(MAXI), 1);

    // Asynchronous reset in the middle of the accumulate loop.
    opa = 16'd5;
    opb = 16'd10;
    op_valid = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("in_add", 32'({LdP, decB}), 32'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), 32'd0);
`ifdef MUL_WDOG_EN
    chk("async_rst_err", 32'(err), 32'd0);
`endif
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_mul(16'd2, 16'd3, 0);

    for (int n = 0; n < 8; n++) begin
      run_mul(16'($urandom), 16'($urandom_range(0, 24)),
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
